// File: rtl/weight_pkg.sv
// Shared constants for the weight preload sequencer.
// Kernel geometry, FSM state encoding and counter width.
package weight_pkg;
   localparam int KERNEL_DIM = 5;
   localparam int COL_W      = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_READY = 2'd3;
endpackage

// File: rtl/valid_delay_line.sv
// Fixed-length 1-bit delay line that realigns bram_en with BRAM read data.
// Cleared asynchronously so no stale pulse survives a reset.
module valid_delay_line #(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   output logic out_valid
);
   logic [LAT-1:0] pipe_q, pipe_d;

   always_comb begin
      pipe_d    = '0;
      pipe_d[0] = in_valid;
      for (int i = 1; i < LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= pipe_d;
   end

   assign out_valid = pipe_q[LAT-1];
endmodule

// File: rtl/weight_preload_ctrl.sv
// Sequencer that streams one 5x5 binary kernel from BRAM into the preload
// shift array and holds weight_ready until the consumer is done with it.
module weight_preload_ctrl #(
   parameter int ADDR_W       = 10,
   parameter int KIDX_W       = 6,
   parameter int NUM_KERNELS  = 64,
   parameter int BASE_ADDR    = 0,
   parameter int BRAM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [KIDX_W-1:0] kernel_idx,
   input  logic              weight_release,
   output logic              start_ack,
   output logic              start_err,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              preload_valid,
   output logic              busy,
   output logic              weight_ready
);
   import weight_pkg::*;

   logic [1:0]        state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [COL_W-1:0]  vcnt_q, vcnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] idx_ext;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              idx_ok, can_accept, accept;
   logic              pv;

   always_comb begin
      idx_ext    = ADDR_W'(kernel_idx);
      idx_ok     = 32'(kernel_idx) < NUM_KERNELS;
      can_accept = (state_q == ST_IDLE) || (state_q == ST_READY);
      accept     = start && can_accept && idx_ok;

      state_d = state_q;
      col_d   = col_q;
      vcnt_d  = vcnt_q;
      base_d  = base_q;
      ack_d   = accept;
      err_d   = start && !accept;

      if (accept) begin
         state_d = ST_FETCH;
         col_d   = '0;
         vcnt_d  = '0;
         // idx*5 as a shift-add, wrapped to the BRAM address space
         base_d  = ADDR_W'(BASE_ADDR) + (idx_ext << 2) + idx_ext;
      end else begin
         if (pv && busy) vcnt_d = vcnt_q + 1'b1;
         case (state_q)
            ST_FETCH: begin
               if (col_q == COL_W'(KERNEL_DIM - 1)) state_d = ST_DRAIN;
               else                                 col_d   = col_q + 1'b1;
            end
            ST_DRAIN: begin
               if (pv && vcnt_q == COL_W'(KERNEL_DIM - 1)) state_d = ST_READY;
            end
            ST_READY: begin
               if (weight_release) state_d = ST_IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         vcnt_q  <= '0;
         base_q  <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         vcnt_q  <= vcnt_d;
         base_q  <= base_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   valid_delay_line #(
      .LAT (BRAM_LATENCY)
   ) u_vdl (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bram_en),
      .out_valid (pv)
   );

   // column counter parks at its last value, so the address holds too
   assign bram_en       = (state_q == ST_FETCH);
   assign bram_addr     = base_q + ADDR_W'(col_q);
   assign busy          = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign weight_ready  = (state_q == ST_READY);
   assign preload_valid = pv;
   assign start_ack     = ack_q;
   assign start_err     = err_q;
endmodule

// File: tb/tb_weight_preload_ctrl.sv
// Directed bench for weight_preload_ctrl at BRAM latency 1 and 3,
// with a BRAM model feeding a model of the preload shift array.
module tb_weight_preload_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       rel = 1'b0;
   logic [6:0] kidx = '0;
   logic       start3 = 1'b0;
   logic [5:0] kidx3 = '0;

   logic       ack, err, en, pv, busy, rdy;
   logic [9:0] addr;
   logic       ack3, err3, en3, pv3, busy3, rdy3;
   logic [9:0] addr3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   weight_preload_ctrl #(
      .ADDR_W(10), .KIDX_W(7), .NUM_KERNELS(64),
      .BASE_ADDR(0), .BRAM_LATENCY(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .kernel_idx(kidx),
      .weight_release(rel), .start_ack(ack), .start_err(err),
      .bram_en(en), .bram_addr(addr), .preload_valid(pv),
      .busy(busy), .weight_ready(rdy)
   );

   weight_preload_ctrl #(
      .ADDR_W(10), .KIDX_W(6), .NUM_KERNELS(64),
      .BASE_ADDR(0), .BRAM_LATENCY(3)
   ) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .kernel_idx(kidx3),
      .weight_release(1'b0), .start_ack(ack3), .start_err(err3),
      .bram_en(en3), .bram_addr(addr3), .preload_valid(pv3),
      .busy(busy3), .weight_ready(rdy3)
   );

   function automatic logic [4:0] mem_word(input logic [9:0] a);
      return a[4:0] ^ 5'h0a;
   endfunction

   logic [4:0] rd;
   logic [4:0] col [5];

   always @(posedge clk) if (en) rd <= mem_word(addr);

   always @(posedge clk) begin
      if (pv) begin
         col[0] <= rd;
         for (int i = 1; i < 5; i++) col[i] <= col[i-1];
      end
   end

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // rej>0 injects a second start while the load is in flight
   task automatic load1(input logic [6:0] idx, input logic r,
                        input int rej);
      start = 1'b1;
      kidx  = idx;
      rel   = r;
      @(negedge clk);
      start = 1'b0;
      rel   = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         if (n > 1) @(negedge clk);
         check("ack", 16'(ack), 16'(n == 1));
         check("err", 16'(err), 16'(rej > 0 && n == rej + 1));
         check("en", 16'(en), 16'(n <= 5));
         if (n <= 5) check("addr", 16'(addr), 16'(int'(idx) * 5 + n - 1));
         check("pv", 16'(pv), 16'(n >= 2 && n <= 6));
         check("busy", 16'(busy), 16'(n <= 6));
         check("rdy", 16'(rdy), 16'(n >= 7));
         start = (n == rej);
         if (n == rej) kidx = 7'd2;
      end
      start = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_en", 16'(en), 16'(0));
      check("rst_addr", 16'(addr), 16'(0));
      check("rst_pv", 16'(pv), 16'(0));
      check("rst_busy", 16'(busy), 16'(0));
      check("rst_rdy", 16'(rdy), 16'(0));
      check("rst_ack", 16'(ack), 16'(0));
      check("rst_err", 16'(err), 16'(0));
      rst_n = 1'b1;
      @(negedge clk);

      load1(7'd3, 1'b0, 0);
      for (int k = 0; k < 5; k++) begin
         check("col", 16'(col[4-k]), 16'(mem_word(10'(15 + k))));
      end

      rel = 1'b1;
      @(negedge clk);
      rel = 1'b0;
      check("rel_rdy", 16'(rdy), 16'(0));
      check("rel_busy", 16'(busy), 16'(0));

      start = 1'b1;
      kidx  = 7'd64;
      @(negedge clk);
      start = 1'b0;
      check("range_err", 16'(err), 16'(1));
      check("range_ack", 16'(ack), 16'(0));
      for (int n = 0; n < 4; n++) begin
         check("range_en", 16'(en), 16'(0));
         check("range_busy", 16'(busy), 16'(0));
         @(negedge clk);
      end

      load1(7'd3, 1'b0, 3);
      load1(7'd1, 1'b1, 0);

      start3 = 1'b1;
      kidx3  = 6'd0;
      @(negedge clk);
      start3 = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         if (n > 1) @(negedge clk);
         check("l3_ack", 16'(ack3), 16'(n == 1));
         check("l3_en", 16'(en3), 16'(n <= 5));
         if (n <= 5) check("l3_addr", 16'(addr3), 16'(n - 1));
         check("l3_pv", 16'(pv3), 16'(n >= 4 && n <= 8));
         check("l3_rdy", 16'(rdy3), 16'(n >= 9));
         check("l3_err", 16'(err3), 16'(0));
      end

      start = 1'b1;
      kidx  = 7'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("drain_busy", 16'(busy), 16'(1));
      check("drain_en", 16'(en), 16'(0));
      rst_n = 1'b0;
      #1;
      check("mr_en", 16'(en), 16'(0));
      check("mr_addr", 16'(addr), 16'(0));
      check("mr_pv", 16'(pv), 16'(0));
      check("mr_busy", 16'(busy), 16'(0));
      check("mr_rdy", 16'(rdy), 16'(0));
      check("mr_ack", 16'(ack), 16'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         check("post_pv", 16'(pv), 16'(0));
         check("post_en", 16'(en), 16'(0));
         check("post_rdy", 16'(rdy), 16'(0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
